// File: rtl/bits32_demux1to2.sv
// Registered 1-to-2 demultiplexer: one valid/ready input stream is steered by Select into
// two single-entry output slots. Optional transfer counters are enabled with DEMUX_STATS_EN.
module bits32_demux1to2 #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Input,
    input  logic             Select,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out0,
    output logic             Out0Valid,
    input  logic             Out0Ready,
    output logic [WIDTH-1:0] Out1,
    output logic             Out1Valid,
    input  logic             Out1Ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] Count0,
    output logic [CNT_WIDTH-1:0] Count1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    logic [1:0]            ready;
    logic [1:0]            valid;
    logic [1:0]            load;
    logic [1:0][WIDTH-1:0] data;
    logic                  accept;

    assign ready = {Out1Ready, Out0Ready};

    // The target slot can take a word if it is empty or is being drained this cycle.
    assign InReady = !Reset && (!valid[Select] || ready[Select]);
    assign accept  = InValid && InReady;

    for (genvar n = 0; n < 2; n++) begin : g_slot
        slot_state_t      state_q, state_d;
        logic [WIDTH-1:0] data_q;

        assign load[n]  = accept && (Select == (n == 1));
        assign valid[n] = (state_q == FULL);
        assign data[n]  = data_q;

        always_comb begin
            state_d = state_q;
            case (state_q)
                EMPTY:   if (load[n]) state_d = FULL;
                FULL:    if (!load[n] && ready[n]) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state_q <= EMPTY;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                if (load[n]) data_q <= Input;
            end
        end
    end

    assign Out0      = data[0];
    assign Out1      = data[1];
    assign Out0Valid = valid[0];
    assign Out1Valid = valid[1];

`ifdef DEMUX_STATS_EN
    logic [1:0][CNT_WIDTH-1:0] cnt;

    // Counters track completed output transfers and wrap naturally.
    for (genvar n = 0; n < 2; n++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) cnt_q <= '0;
            else if (valid[n] && ready[n]) cnt_q <= cnt_q + 1'b1;
        end

        assign cnt[n] = cnt_q;
    end

    assign Count0 = cnt[0];
    assign Count1 = cnt[1];
`endif

endmodule

// File: tb/tb_bits32_demux1to2.sv
// Self-checking bench for bits32_demux1to2: directed table, reset/stall sequences,
// a streaming scoreboard and randomized traffic against a depth-1 slot model.
module tb_bits32_demux1to2;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Input;
    logic        Select, InValid, InReady;
    logic [31:0] Out0, Out1;
    logic        Out0Valid, Out1Valid, Out0Ready, Out1Ready;
`ifdef DEMUX_STATS_EN
    logic [7:0]  Count0, Count1;
`endif

    always #5 Clk = ~Clk;

    bits32_demux1to2 #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Input(Input), .Select(Select),
        .InValid(InValid), .InReady(InReady),
        .Out0(Out0), .Out0Valid(Out0Valid), .Out0Ready(Out0Ready),
        .Out1(Out1), .Out1Valid(Out1Valid), .Out1Ready(Out1Ready)
`ifdef DEMUX_STATS_EN
        , .Count0(Count0), .Count1(Count1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at posedge+1, report InReady seen before the edge,
    // return at posedge+1 of the following edge.
    task automatic apply(input logic sel, input logic iv, input logic r0, input logic r1,
                         input logic [31:0] din, output logic rdy_seen);
        Select = sel; InValid = iv; Out0Ready = r0; Out1Ready = r1; Input = din;
        #1 rdy_seen = InReady;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; InValid = 1'b0; Select = 1'b0; Out0Ready = 1'b0; Out1Ready = 1'b0;
        Input = '0;
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    // Reference: each destination is a buffer holding at most one word.
    logic        m_v [2];
    logic [31:0] m_d [2];

    function automatic logic model_ready(input logic sel, input logic r0, input logic r1);
        logic r [2];
        r[0] = r0; r[1] = r1;
        return !m_v[sel] || r[sel];
    endfunction

    task automatic model_step(input logic sel, input logic iv, input logic r0, input logic r1,
                              input logic [31:0] din);
        logic r [2];
        logic acc;
        r[0] = r0; r[1] = r1;
        acc = iv && model_ready(sel, r0, r1);
        for (int n = 0; n < 2; n++) begin
            if (m_v[n] && r[n]) m_v[n] = 1'b0;
            if (acc && int'(sel) == n) begin
                m_v[n] = 1'b1;
                m_d[n] = din;
            end
        end
    endtask

    typedef struct {
        logic        sel, iv, r0, r1;
        logic [31:0] din;
        logic        e_rdy, e_v0, e_v1;
        logic [31:0] e_o0, e_o1;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic        rdy;
        logic [31:0] q0 [$];
        logic [31:0] q1 [$];

        vecs[0] = '{1, 1, 0, 1, 32'h0000_0001, 1, 0, 1, 32'h0,         32'h1};
        vecs[1] = '{0, 0, 0, 1, 32'h0,         1, 0, 0, 32'h0,         32'h1};
        vecs[2] = '{0, 1, 0, 0, 32'hAAAA_5555, 1, 1, 0, 32'hAAAA_5555, 32'h1};
        vecs[3] = '{0, 1, 0, 0, 32'h1234_5678, 0, 1, 0, 32'hAAAA_5555, 32'h1};
        vecs[4] = '{0, 1, 1, 0, 32'h1234_5678, 1, 1, 0, 32'h1234_5678, 32'h1};
        vecs[5] = '{1, 1, 0, 0, 32'hDEAD_BEEF, 1, 1, 1, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[6] = '{0, 1, 0, 1, 32'h0000_0055, 0, 1, 0, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[7] = '{0, 0, 1, 0, 32'h0,         1, 0, 0, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[8] = '{1, 1, 1, 1, 32'hCAFE_F00D, 1, 0, 1, 32'h1234_5678, 32'hCAFE_F00D};

        do_reset();
        chk("reset_out0", Out0, 32'h0);
        chk("reset_out1", Out1, 32'h0);
        chk("reset_valids", {30'h0, Out1Valid, Out0Valid}, 32'h0);

        // Directed table: single transfer, stall/drain+fill, independence, ignored ready.
        foreach (vecs[i]) begin
            apply(vecs[i].sel, vecs[i].iv, vecs[i].r0, vecs[i].r1, vecs[i].din, rdy);
            chk($sformatf("tbl%0d_inready", i), {31'h0, rdy}, {31'h0, vecs[i].e_rdy});
            chk($sformatf("tbl%0d_v0", i), {31'h0, Out0Valid}, {31'h0, vecs[i].e_v0});
            chk($sformatf("tbl%0d_v1", i), {31'h0, Out1Valid}, {31'h0, vecs[i].e_v1});
            chk($sformatf("tbl%0d_out0", i), Out0, vecs[i].e_o0);
            chk($sformatf("tbl%0d_out1", i), Out1, vecs[i].e_o1);
        end

        // Asynchronous reset mid-cycle with both slots full.
        do_reset();
        apply(0, 1, 0, 0, 32'h1111_1111, rdy);
        apply(1, 1, 0, 0, 32'h2222_2222, rdy);
        chk("prereset_both_full", {30'h0, Out1Valid, Out0Valid}, 32'h3);
        InValid = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk("async_out0", Out0, 32'h0);
        chk("async_out1", Out1, 32'h0);
        chk("async_valids", {30'h0, Out1Valid, Out0Valid}, 32'h0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        Select = 1'b0;
        #1 chk("post_reset_inready_s0", {31'h0, InReady}, 32'h1);
        Select = 1'b1;
        #1 chk("post_reset_inready_s1", {31'h0, InReady}, 32'h1);
        @(posedge Clk);
        #1;

        // Back-to-back alternating stream with both consumers ready.
        for (int i = 0; i < 18; i++) begin
            logic [31:0] w;
            if (Out0Valid) begin
                if (q0.size() == 0) chk("stream_out0_extra", Out0, 32'hFFFF_FFFF);
                else chk($sformatf("stream_out0_%0d", i), Out0, q0.pop_front());
            end
            if (Out1Valid) begin
                if (q1.size() == 0) chk("stream_out1_extra", Out1, 32'hFFFF_FFFF);
                else chk($sformatf("stream_out1_%0d", i), Out1, q1.pop_front());
            end
            w = 32'hA500_0000 + 32'(i);
            if (i < 16) begin
                apply(i[0], 1, 1, 1, w, rdy);
                chk($sformatf("stream_inready_%0d", i), {31'h0, rdy}, 32'h1);
                if (i[0]) q1.push_back(w);
                else q0.push_back(w);
            end else begin
                apply(0, 0, 1, 1, 32'h0, rdy);
            end
        end
        chk("stream_all_delivered", 32'(q0.size() + q1.size()), 32'h0);

        // Randomized traffic against the buffer model.
        do_reset();
        m_v[0] = 0; m_v[1] = 0; m_d[0] = '0; m_d[1] = '0;
        for (int i = 0; i < 400; i++) begin
            logic        sel, iv, r0, r1, erdy;
            logic [31:0] din;
            sel = 1'($urandom); iv = ($urandom_range(0, 3) != 0);
            r0 = 1'($urandom); r1 = ($urandom_range(0, 2) != 0); din = $urandom;
            erdy = model_ready(sel, r0, r1);
            apply(sel, iv, r0, r1, din, rdy);
            model_step(sel, iv, r0, r1, din);
            chk($sformatf("rnd%0d_inready", i), {31'h0, rdy}, {31'h0, erdy});
            chk($sformatf("rnd%0d_v0", i), {31'h0, Out0Valid}, {31'h0, m_v[0]});
            chk($sformatf("rnd%0d_v1", i), {31'h0, Out1Valid}, {31'h0, m_v[1]});
            chk($sformatf("rnd%0d_out0", i), Out0, m_d[0]);
            chk($sformatf("rnd%0d_out1", i), Out1, m_d[1]);
        end

`ifdef DEMUX_STATS_EN
        // Transfer counters: 257 to slot 0 wraps to 1, 3 to slot 1.
        do_reset();
        chk("cnt_reset0", {24'h0, Count0}, 32'h0);
        chk("cnt_reset1", {24'h0, Count1}, 32'h0);
        for (int i = 0; i < 257; i++) apply(0, 1, 1, 0, 32'(i), rdy);
        apply(0, 0, 1, 0, 32'h0, rdy);
        for (int i = 0; i < 3; i++) apply(1, 1, 0, 1, 32'(i), rdy);
        apply(0, 0, 0, 1, 32'h0, rdy);
        apply(0, 0, 0, 0, 32'h0, rdy);
        chk("cnt_slot0_wrap", {24'h0, Count0}, 32'h1);
        chk("cnt_slot1", {24'h0, Count1}, 32'h3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bits32_demux1to2.md
Name: bits32_demux1to2

Overview:
Registered 32-bit 1-to-2 demultiplexer. It is the counterpart of the 32-bit 2-to-1 mux in the datapath: it steers one input word stream to one of two destinations, chosen by Select.
- Each destination has a single-entry output register with a valid/ready handshake, so a stalled destination never corrupts or drops data.
- Used where one producer (e.g. ALU result / writeback path) feeds two consumers.

Parameters:
WIDTH, 32, data word width
CNT_WIDTH, 8, width of transfer counters (only used with DEMUX_STATS_EN)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Input  input  WIDTH  data word to route
Select  input  1  destination: 0 -> Out0, 1 -> Out1; sampled only on accept
InValid  input  1  Input/Select valid this cycle
InReady  output  1  block can accept Input this cycle
Out0  output  WIDTH  slot 0 data
Out0Valid  output  1  slot 0 holds a word
Out0Ready  input  1  consumer 0 takes the word this cycle
Out1  output  WIDTH  slot 1 data
Out1Valid  output  1  slot 1 holds a word
Out1Ready  input  1  consumer 1 takes the word this cycle

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values (immediate, not clock-dependent): Out0=0, Out1=0, Out0Valid=0, Out1Valid=0.
- Reset mid-operation discards any held words; no handshake completes while Reset=1.
- Per-slot state machine n∈{0,1}, EMPTY/FULL, encoded by OutnValid:
  - EMPTY -> FULL on accept with Select=n.
  - FULL -> EMPTY on OutnReady=1 with no accept to slot n that cycle.
  - FULL -> FULL with new data on a simultaneous drain and accept to slot n.
  - FULL -> FULL, data held, when OutnReady=0.
- InReady (combinational) = !OutsValid | OutsReady, where s = Select. It does not depend on InValid.
- Accept = InValid & InReady. On accept, slot s loads Input at the next Clk edge and OutsValid=1.
- Latency: 1 cycle from accept to OutsValid.
- Throughput: 1 word/cycle sustained to a single slot whose consumer holds OutsReady=1.
- Independence: the unselected slot is unaffected by input activity and drains on its own Ready. Filling slot 0 while slot 1 drains happens in the same cycle.
- Out data stability: Outn changes only on an accept to slot n, and stays constant while OutnValid=1 & OutnReady=0.
- No data path between slots; the word in one slot is never copied to the other.
- Ready with Valid=0 at an output is ignored.
- InValid=0: Input and Select are don't-care, and no state changes except drains.
- Select changing while InValid=1 & InReady=0 is legal: InReady re-evaluates against the new target.

Optional Feature:
Macro DEMUX_STATS_EN.
- Defined: adds output ports Count0 and Count1, each CNT_WIDTH wide, reset to 0.
  - Countn increments by 1 on every completed output transfer (OutnValid & OutnReady).
  - Countn wraps from 2^CNT_WIDTH-1 to 0.
  - Simultaneous transfers on both slots increment both counters.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset=1 asynchronously mid-cycle with both slots FULL -> Out0/Out1=0 and both Valids=0 immediately; InReady=1 after release.
2. Input=0x00000001, Select=1, InValid=1 for one cycle, Out1Ready=1 -> next cycle Out1=0x00000001 and Out1Valid=1; Out0Valid stays 0; following cycle Out1Valid=0.
3. Out0Ready=0; push 0xAAAA5555 with Select=0, then present 0x12345678 with Select=0 -> InReady=0; Out0 holds 0xAAAA5555. Raise Out0Ready -> same-cycle drain+fill; next cycle Out0=0x12345678 with Out0Valid still 1.
4. Slot 0 stalled FULL; present 0xDEADBEEF with Select=1 -> InReady=1 and word lands in Out1; Out0 unchanged.
5. Back-to-back 16 words alternating Select=0,1 with both Ready=1 -> InValid=InReady=1 every cycle; each word appears at the correct output exactly once, in order.
6. DEMUX_STATS_EN with CNT_WIDTH=8: 257 transfers to slot 0 and 3 to slot 1 -> Count0=1, Count1=3.
